mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 38 +++
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit: access-size encodings, FSM states, default memory size.
// Sub-word (byte/half) support is compiled in only when MEM_ACCESS_SUBWORD_EN is defined.
package mem_access_pkg;

  localparam int MEM_BYTES_DEF = 1024;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

`ifdef MEM_ACCESS_SUBWORD_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RESP   = 3'd5
  } state_e;
`endif

  // Natural alignment: halves on even addresses, words on multiples of four.
  function automatic logic lane_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-memory bus of the memory access unit.
// slave = the unit itself, master = the requester and memory side.
interface mem_access_unit_if;

  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_SIGNED;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [31:0] MEM_ADDR;
  logic        MEM_RW;
  logic [31:0] MEM_WD;
  logic [31:0] MEM_RD;

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_SIZE, REQ_SIGNED, REQ_ADDR, REQ_WDATA, MEM_RD,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, MEM_ADDR, MEM_RW, MEM_WD
  );

  modport master (
    output REQ_VALID, REQ_WE, REQ_SIZE, REQ_SIGNED, REQ_ADDR, REQ_WDATA, MEM_RD,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, MEM_ADDR, MEM_RW, MEM_WD
  );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends sub-word loads, and merges
// sub-word store data into an existing memory word. Purely combinational.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wr_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    lane_b     = rd_word[{addr_lo, 3'b000} +: 8];
    lane_h     = rd_word[{addr_lo[1], 4'b0000} +: 16];
    load_data  = rd_word;
    merge_word = wr_data;
    case (size)
      SZ_BYTE: begin
        load_data  = sign_ext ? 32'(lane_b) : {24'h0, lane_b};
        merge_word = old_word;
        merge_word[{addr_lo, 3'b000} +: 8] = wr_data[7:0];
      end
      SZ_HALF: begin
        load_data  = sign_ext ? 32'(lane_h) : {16'h0, lane_h};
        merge_word = old_word;
        merge_word[{addr_lo[1], 4'b0000} +: 16] = wr_data[15:0];
      end
      default: begin
        load_data  = rd_word;
        merge_word = wr_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a single-request port and a word-wide data memory.
// Define MEM_ACCESS_SUBWORD_EN for byte/half accesses (read-modify-write stores).
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input logic CLK,
  input logic RST,
  mem_access_unit_if.slave bus
);

  state_e      state, state_nxt;
  logic        accept, req_err, size_bad, misalign, out_of_range;
  logic        err_q, we_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q, old_word, load_data, merge_word, word_addr;

  assign accept = bus.REQ_VALID && bus.REQ_READY;

`ifdef MEM_ACCESS_SUBWORD_EN
  assign size_bad = (bus.REQ_SIZE == SZ_ILL);
`else
  assign size_bad = (bus.REQ_SIZE != SZ_WORD);
`endif
  assign misalign     = lane_misaligned(bus.REQ_SIZE, bus.REQ_ADDR[1:0]);
  assign out_of_range = (bus.REQ_ADDR >= 32'(MEM_BYTES));
  assign req_err      = size_bad || misalign || out_of_range;
  assign word_addr    = {addr_q[31:2], 2'b00};

  mem_lane_align u_align (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .sign_ext   (signed_q),
    .rd_word    (bus.MEM_RD),
    .old_word   (old_word),
    .wr_data    (wdata_q),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) err_q <= req_err;
    end
  end

  // Request fields and load data are plain datapath registers.
  always_ff @(posedge CLK) begin
    if (accept) begin
      we_q     <= bus.REQ_WE;
      size_q   <= bus.REQ_SIZE;
      signed_q <= bus.REQ_SIGNED;
      addr_q   <= bus.REQ_ADDR;
      wdata_q  <= bus.REQ_WDATA;
    end
    rdata_q <= (state == LOAD) ? load_data : '0;
  end

`ifdef MEM_ACCESS_SUBWORD_EN
  logic [31:0] rmw_q;
  always_ff @(posedge CLK) begin
    if (state == RMW_RD) rmw_q <= bus.MEM_RD;
  end
  assign old_word = rmw_q;
`else
  assign old_word = '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)              state_nxt = RESP;
          else if (!bus.REQ_WE)     state_nxt = LOAD;
`ifdef MEM_ACCESS_SUBWORD_EN
          else if (bus.REQ_SIZE != SZ_WORD) state_nxt = RMW_RD;
`endif
          else                      state_nxt = STORE;
        end
      end
      LOAD:    state_nxt = RESP;
      STORE:   state_nxt = RESP;
`ifdef MEM_ACCESS_SUBWORD_EN
      RMW_RD:  state_nxt = RMW_WR;
      RMW_WR:  state_nxt = RESP;
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs idle at zero; IDLE is the reset state, so reset forces them low.
  always_comb begin
    bus.REQ_READY = 1'b0;
    bus.RSP_VALID = 1'b0;
    bus.RSP_ERR   = 1'b0;
    bus.RSP_RDATA = '0;
    bus.MEM_ADDR  = '0;
    bus.MEM_RW    = 1'b0;
    bus.MEM_WD    = '0;
    case (state)
      IDLE:  bus.REQ_READY = !RST;
      LOAD:  bus.MEM_ADDR  = word_addr;
      STORE: begin
        bus.MEM_ADDR = word_addr;
        bus.MEM_RW   = 1'b1;
        bus.MEM_WD   = merge_word;
      end
`ifdef MEM_ACCESS_SUBWORD_EN
      RMW_RD: bus.MEM_ADDR = word_addr;
      RMW_WR: begin
        bus.MEM_ADDR = word_addr;
        bus.MEM_RW   = 1'b1;
        bus.MEM_WD   = merge_word;
      end
`endif
      RESP: begin
        bus.RSP_VALID = 1'b1;
        bus.RSP_ERR   = err_q;
        bus.RSP_RDATA = rdata_q;
      end
      default: ;
    endcase
  end

  logic unused_we;
  assign unused_we = we_q;

endmodule
